// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: byte-stream serializer with a programmable bit-pattern
// detector, saturating match counter and threshold-driven halt/interrupt.
module pattern_scan_ctrl #(
    parameter int PAT_W = 6,
    parameter int LEN_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             irq
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_HALT} state_t;

    localparam logic [LEN_W:0]   PAT_W_L = (LEN_W+1)'(PAT_W);
    localparam logic [LEN_W-1:0] VCNT_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] sat_vcnt(input logic [LEN_W:0] v);
        return (v > PAT_W_L) ? VCNT_MAX : v[LEN_W-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    // Only PAT_W-1 history bits are kept: the oldest bit of a PAT_W window
    // is always the one about to fall out, so it is never compared again.
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] vcnt_q, vcnt_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       bidx_q, bidx_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;

    logic [LEN_W:0]   eff_len;
    logic [LEN_W:0]   vcnt_inc;
    logic [PAT_W-1:0] cand;
    logic [PAT_W:0]   mask_w;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;

    // State and datapath registers; reset clears everything, configuration included
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            thr_q   <= '0;
            hist_q  <= '0;
            vcnt_q  <= '0;
            sh_q    <= '0;
            bidx_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            thr_q   <= thr_d;
            hist_q  <= hist_d;
            vcnt_q  <= vcnt_d;
            sh_q    <= sh_d;
            bidx_q  <= bidx_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    // Next-state and register update logic, including the per-bit pattern compare
    always_comb begin
        eff_len  = ({1'b0, len_q} > PAT_W_L) ? PAT_W_L : {1'b0, len_q};
        vcnt_inc = {1'b0, vcnt_q} + 1'b1;
        cand     = {hist_q, sh_q[bidx_q]};
        mask_w   = ((PAT_W+1)'(1) << eff_len) - (PAT_W+1)'(1);
        hit      = (eff_len != '0) && (vcnt_inc >= eff_len) &&
                   (((cand ^ pat_q) & mask_w[PAT_W-1:0]) == '0);
        cnt_inc  = sat_inc_cnt(cnt_q);

        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        thr_d   = thr_q;
        hist_d  = hist_q;
        vcnt_d  = vcnt_q;
        sh_d    = sh_q;
        bidx_d  = bidx_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        irq_d   = irq_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                    thr_d = cfg_thresh;
                end
                if (start) begin
                    state_d = S_WAIT;
                    hist_d  = '0;
                    vcnt_d  = '0;
                    cnt_d   = '0;
                    irq_d   = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (in_valid) begin
                    sh_d    = in_data;
                    bidx_d  = 3'd7;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                hist_d = cand[PAT_W-2:0];
                vcnt_d = sat_vcnt(vcnt_inc);
                if (hit) begin
                    match_d = 1'b1;
                    cnt_d   = cnt_inc;
                end
                // stop wins over a threshold hit; the pulse and count still land
                if (stop) begin
                    state_d = S_IDLE;
                end else if (hit && (thr_q != '0) && (cnt_inc == thr_q)) begin
                    state_d = S_HALT;
                    irq_d   = 1'b1;
                end else if (bidx_q == 3'd0) begin
                    state_d = S_WAIT;
                end else begin
                    bidx_d = bidx_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registered flags only
    always_comb begin
        in_ready    = (state_q == S_WAIT);
        busy        = (state_q == S_WAIT) || (state_q == S_SHIFT);
        match       = match_q;
        match_count = cnt_q;
        irq         = irq_q;
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [5:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic [7:0] cfg_thresh;
    logic       start, stop, in_valid;
    logic [7:0] in_data;
    logic       in_ready, match, busy, irq;
    logic [7:0] match_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] mvec, rvec;

    pattern_scan_ctrl #(.PAT_W(6), .LEN_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .match(match), .match_count(match_count), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic program_start(input logic [5:0] p, input logic [2:0] l, input logic [7:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic handshake(input logic [7:0] d);
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Advance n cycles, recording match and in_ready after each edge
    task automatic shift_ticks(input int n);
        mvec = '0; rvec = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            mvec[k] = match;
            rvec[k] = in_ready;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        chk("reset_in_ready", {7'd0, in_ready}, 8'd0);
        chk("reset_match", {7'd0, match}, 8'd0);
        chk("reset_count", match_count, 8'd0);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_irq", {7'd0, irq}, 8'd0);
        reset = 1'b1;
        tick();
        chk("idle_in_ready", {7'd0, in_ready}, 8'd0);
    endtask

    task automatic test_single_match();
        program_start(6'b100111, 3'd6, 8'd0);
        chk("t1_wait_ready", {7'd0, in_ready}, 8'd1);
        chk("t1_wait_busy", {7'd0, busy}, 8'd1);
        handshake(8'b10011100);
        chk("t1_shift_ready", {7'd0, in_ready}, 8'd0);
        shift_ticks(8);
        chk("t1_match_pos", mvec, 8'b0010_0000);
        chk("t1_ready_pos", rvec, 8'b1000_0000);
        chk("t1_count", match_count, 8'd1);
    endtask

    task automatic test_overlap();
        do_stop();
        chk("t2_stopped_ready", {7'd0, in_ready}, 8'd0);
        program_start(6'b000101, 3'd3, 8'd0);
        chk("t2_count_cleared", match_count, 8'd0);
        handshake(8'h15);
        shift_ticks(8);
        chk("t2_match_pos", mvec, 8'b1010_0000);
        chk("t2_count", match_count, 8'd2);
    endtask

    task automatic test_cross_byte();
        do_stop();
        program_start(6'b000011, 3'd2, 8'd0);
        handshake(8'h01);
        shift_ticks(8);
        chk("t3_byte1_match", mvec, 8'h00);
        handshake(8'h80);
        shift_ticks(8);
        chk("t3_byte2_match", mvec, 8'b0000_0001);
        chk("t3_count", match_count, 8'd1);
    endtask

    task automatic test_threshold();
        do_stop();
        program_start(6'b000011, 3'd2, 8'd2);
        handshake(8'hFF);
        shift_ticks(3);
        chk("t4_match_pos", mvec, 8'b0000_0110);
        chk("t4_count", match_count, 8'd2);
        chk("t4_irq", {7'd0, irq}, 8'd1);
        chk("t4_ready", {7'd0, in_ready}, 8'd0);
        chk("t4_busy", {7'd0, busy}, 8'd0);
        in_valid = 1'b1; in_data = 8'hFF;
        shift_ticks(4);
        in_valid = 1'b0;
        chk("t4_halt_nomatch", mvec, 8'h00);
        chk("t4_halt_count", match_count, 8'd2);
        chk("t4_halt_irq", {7'd0, irq}, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_irq", {7'd0, irq}, 8'd0);
        chk("t4_restart_count", match_count, 8'd0);
        chk("t4_restart_ready", {7'd0, in_ready}, 8'd1);
    endtask

    task automatic test_stop();
        do_stop();
        program_start(6'b000011, 3'd2, 8'd0);
        handshake(8'hE0);
        shift_ticks(3);
        chk("t5_pre_count", match_count, 8'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_ready", {7'd0, in_ready}, 8'd0);
        chk("t5_stop_busy", {7'd0, busy}, 8'd0);
        chk("t5_stop_count", match_count, 8'd2);
        chk("t5_stop_match", {7'd0, match}, 8'd0);
        in_valid = 1'b1; in_data = 8'hFF;
        shift_ticks(8);
        in_valid = 1'b0;
        chk("t5_after_match", mvec, 8'h00);
        chk("t5_after_ready", rvec, 8'h00);
        chk("t5_after_count", match_count, 8'd2);
    endtask

    task automatic test_len_clamp();
        program_start(6'b111111, 3'd7, 8'd0);
        handshake(8'hFF);
        shift_ticks(8);
        chk("clamp_match_pos", mvec, 8'b1110_0000);
        chk("clamp_count", match_count, 8'd3);
    endtask

    task automatic test_reset_mid_shift();
        do_stop();
        program_start(6'b000011, 3'd2, 8'd0);
        handshake(8'hFF);
        shift_ticks(4);
        chk("t6_pre_count", match_count, 8'd3);
        reset = 1'b0;
        tick();
        chk("t6_rst_ready", {7'd0, in_ready}, 8'd0);
        chk("t6_rst_match", {7'd0, match}, 8'd0);
        chk("t6_rst_count", match_count, 8'd0);
        chk("t6_rst_busy", {7'd0, busy}, 8'd0);
        chk("t6_rst_irq", {7'd0, irq}, 8'd0);
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_start_ready", {7'd0, in_ready}, 8'd1);
        handshake(8'hFF);
        shift_ticks(8);
        chk("t6_cfg_cleared_match", mvec, 8'h00);
        chk("t6_cfg_cleared_count", match_count, 8'd0);
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0;
        test_reset();
        test_single_match();
        test_overlap();
        test_cross_byte();
        test_threshold();
        test_stop();
        test_len_clamp();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
